// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FSM state type and width helpers for the FFT twiddle address generator
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } fft_state_e;

  function automatic int bfly_w(input int nwl);
    return nwl - 1;
  endfunction

  function automatic int stage_w(input int nwl);
    return (nwl < 2) ? 1 : $clog2(nwl);
  endfunction

  function automatic bit awl_ok(input int nwl, input int awl);
    return awl == nwl - 1;
  endfunction

endpackage

// File: rtl/fft_bfly_counter.sv
// rtl/fft_bfly_counter.sv - nested butterfly (j) / stage (s) counter with wrap and last-butterfly flag
module fft_bfly_counter
  import fft_pkg::*;
#(
  parameter int NWL = 4,
  parameter int SWL = stage_w(NWL)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    adv_i,
  output logic [bfly_w(NWL)-1:0]  j_o,
  output logic [SWL-1:0]          s_o,
  output logic [bfly_w(NWL)-1:0]  j_nxt_o,
  output logic [SWL-1:0]          s_nxt_o,
  output logic                    last_o
);

  localparam int BW = bfly_w(NWL);
  localparam logic [BW-1:0]  J_MAX = '1;
  localparam logic [SWL-1:0] S_MAX = SWL'(NWL - 1);

  logic [BW-1:0]  j_q, j_d;
  logic [SWL-1:0] s_q, s_d;

  // After the final butterfly both counters wrap to zero, ready for the next sweep.
  always_comb begin
    j_d = j_q;
    s_d = s_q;
    if (clr_i) begin
      j_d = '0;
      s_d = '0;
    end else if (adv_i) begin
      if (j_q == J_MAX) begin
        j_d = '0;
        s_d = (s_q == S_MAX) ? '0 : s_q + 1'b1;
      end else begin
        j_d = j_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      j_q <= '0;
      s_q <= '0;
    end else begin
      j_q <= j_d;
      s_q <= s_d;
    end
  end

  assign j_o     = j_q;
  assign s_o     = s_q;
  assign j_nxt_o = j_d;
  assign s_nxt_o = s_d;
  assign last_o  = (j_q == J_MAX) && (s_q == S_MAX);

endmodule

// File: rtl/fft_twiddle_addr_gen.sv
// rtl/fft_twiddle_addr_gen.sv - radix-2 DIT twiddle ROM address sequencer; FFT_TWIDDLE_IDX_EN adds operand index outputs
module fft_twiddle_addr_gen
  import fft_pkg::*;
#(
  parameter int NWL = 4,
  parameter int AWL = NWL - 1,
  parameter int SWL = stage_w(NWL)
) (
  input  logic                   i_CLK,
  input  logic                   i_RESET_N,
  input  logic                   i_START,
  input  logic                   i_READY,
  output logic                   o_VALID,
  output logic [AWL-1:0]         o_ADDR,
  output logic [SWL-1:0]         o_STAGE,
  output logic [bfly_w(NWL)-1:0] o_BFLY,
  output logic [NWL-1:0]         o_IDX_A,
  output logic [NWL-1:0]         o_IDX_B,
  output logic                   o_BUSY,
  output logic                   o_DONE
);

  localparam int BW = bfly_w(NWL);

  if (!awl_ok(NWL, AWL) || NWL < 2) begin : g_bad_cfg
    $error("fft_twiddle_addr_gen: AWL must equal NWL-1 and NWL must be >= 2");
  end

  fft_state_e     state_q, state_d;
  logic [AWL-1:0] addr_q, addr_d;
  logic [BW-1:0]  j, j_nxt;
  logic [SWL-1:0] s, s_nxt;
  logic           last, start, xfer;

  assign start = (state_q == ST_IDLE) && i_START;
  assign xfer  = (state_q == ST_RUN) && i_READY;

  fft_bfly_counter #(.NWL(NWL), .SWL(SWL)) u_cnt (
    .clk_i   (i_CLK),
    .rst_ni  (i_RESET_N),
    .clr_i   (start),
    .adv_i   (xfer),
    .j_o     (j),
    .s_o     (s),
    .j_nxt_o (j_nxt),
    .s_nxt_o (s_nxt),
    .last_o  (last)
  );

  // k = (j mod 2^s) << (NWL-1-s); computed from next-state counters so it registers with them.
  function automatic logic [AWL-1:0] calc_k(input logic [BW-1:0] jj, input logic [SWL-1:0] ss);
    logic [NWL-1:0] one, mask, pos, k;
    one  = NWL'(1);
    mask = (one << ss) - one;
    pos  = {1'b0, jj} & mask;
    k    = pos << (NWL - 1 - int'(ss));
    return k[AWL-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (i_START) state_d = ST_RUN;
      ST_RUN:  if (xfer && last) state_d = ST_FIN;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign addr_d = calc_k(j_nxt, s_nxt);

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

`ifdef FFT_TWIDDLE_IDX_EN
  logic [NWL-1:0] idx_a_q, idx_b_q, idx_a_d, idx_b_d;

  function automatic logic [2*NWL-1:0] calc_idx(input logic [BW-1:0] jj, input logic [SWL-1:0] ss);
    logic [NWL-1:0] one, mask, pos, grp, a, b;
    one  = NWL'(1);
    mask = (one << ss) - one;
    pos  = {1'b0, jj} & mask;
    grp  = {1'b0, jj} >> ss;
    a    = (grp << (int'(ss) + 1)) | pos;
    b    = a + (one << ss);
    return {a, b};
  endfunction

  assign {idx_a_d, idx_b_d} = calc_idx(j_nxt, s_nxt);

  always_ff @(posedge i_CLK or negedge i_RESET_N) begin
    if (!i_RESET_N) begin
      idx_a_q <= '0;
      idx_b_q <= '0;
    end else begin
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
    end
  end

  assign o_IDX_A = idx_a_q;
  assign o_IDX_B = idx_b_q;
`else
  assign o_IDX_A = '0;
  assign o_IDX_B = '0;
`endif

  assign o_VALID = (state_q == ST_RUN);
  assign o_BUSY  = (state_q == ST_RUN);
  assign o_DONE  = (state_q == ST_FIN);
  assign o_ADDR  = addr_q;
  assign o_STAGE = s;
  assign o_BFLY  = j;

endmodule

// File: doc/fft_twiddle_addr_gen.md
Name: fft_twiddle_addr_gen

Overview:
Sequencer that reads the twiddle sin/cos ROM tables for the iterative radix-2 DIT FFT core. For every butterfly of every stage it issues the table address k of W_N^k, plus stage/butterfly counters, under a valid/ready handshake. The butterfly datapath consumes them. It sits between the FFT control FSM (start/done) and the two table instances.
- Table instances: COS=0 and COS=1, AWL=NWL-1, table_division=2.
- The ROM address-to-data path is combinational, so table data is valid in the same cycle as o_ADDR.

Parameters:
NWL, 4, log2 of FFT size N (N=2**NWL, NWL>=2).
AWL, NWL-1, table address width; must equal NWL-1 (elaboration error otherwise).
SWL, $clog2(NWL), stage counter width.

Ports:
i_CLK  in  1  clock, rising edge.
i_RESET_N  in  1  asynchronous active-low reset.
i_START  in  1  start one full FFT address sweep; sampled only in IDLE.
i_READY  in  1  datapath accepts current address.
o_VALID  out  1  o_ADDR/o_STAGE/o_BFLY valid.
o_ADDR  out  AWL  twiddle table address k.
o_STAGE  out  SWL  current stage s, 0..NWL-1.
o_BFLY  out  NWL-1  butterfly index j within stage, 0..N/2-1.
o_IDX_A  out  NWL  top operand index (optional feature).
o_IDX_B  out  NWL  bottom operand index (optional feature).
o_BUSY  out  1  high in RUN.
o_DONE  out  1  one-cycle pulse on sweep completion.

Behaviour:
- Reset is asynchronous and active-low. While i_RESET_N=0 all outputs are 0 and the FSM is in IDLE. Reset asserted mid-sweep aborts immediately; no o_DONE is produced.
- FSM states: IDLE, RUN, FIN.
- IDLE:
  - o_VALID=0.
  - i_START=1 -> s=0, j=0, go to RUN.
  - o_VALID=1 from the next cycle (1-cycle start latency).
- RUN:
  - o_VALID=1 and o_BUSY=1 every cycle.
  - Handshake: a transfer occurs when o_VALID & i_READY.
  - Without a transfer, all outputs hold stable (no change while stalled).
  - On a transfer with j<N/2-1: j<=j+1.
  - On a transfer with j=N/2-1 and s<NWL-1: j<=0, s<=s+1.
  - On a transfer with j=N/2-1 and s=NWL-1: go to FIN, o_VALID<=0.
- FIN: o_DONE=1 for exactly one cycle, o_BUSY=0, then IDLE.
- i_START is ignored in RUN and FIN. i_START=1 held continuously re-launches on the cycle after FIN.
- Address arithmetic, registered alongside the counters:
  - pos = j & (2**s - 1).
  - k = pos << (NWL-1-s).
  - Result is AWL bits, with no overflow by construction.
- Totals: exactly NWL*N/2 transfers per sweep. Minimum sweep = NWL*N/2 + 2 cycles from i_START to o_DONE with i_READY tied high.
- Stage 0 always gives k=0. The last stage gives k=j.

Optional Feature:
Macro FFT_TWIDDLE_IDX_EN.
- Defined:
  - grp = j >> s.
  - o_IDX_A = (grp << (s+1)) | pos.
  - o_IDX_B = o_IDX_A + 2**s.
  - Both are registered together with o_ADDR and follow the same valid/hold rules.
- Undefined: o_IDX_A and o_IDX_B are tied to 0, with no logic generated.
- Ports exist in both cases.

Decomposition:
- Shared package fft_pkg holds:
  - FSM state enum (IDLE/RUN/FIN).
  - Width helper functions for NWL-1, SWL and the AWL check.
- One natural sub-module, fft_bfly_counter: the j/s nested counter with wrap and last flag. The top level holds the FSM, address and index arithmetic, and output registers.

Test Plan:
- NWL=3, i_READY=1, pulse i_START -> o_ADDR sequence over 12 valid cycles: 0,0,0,0 | 0,2,0,2 | 0,1,2,3; o_STAGE 0,0,0,0,1,1,1,1,2,2,2,2; o_DONE one cycle after the last transfer; total 14 cycles from i_START.
- NWL=3, i_READY low 3 cycles at s=1, j=1 -> o_ADDR=2, o_BFLY=1, o_VALID=1 held all 3 cycles; sequence resumes unchanged.
- i_START pulsed mid-sweep (s=1) -> no restart, counters unaffected; a single o_DONE at the end.
- i_RESET_N low asynchronously at s=2, j=2 -> outputs 0 immediately, no o_DONE; the next i_START begins at s=0, j=0.
- FFT_TWIDDLE_IDX_EN, NWL=3, s=1 -> (A,B) pairs (0,2),(1,3),(4,6),(5,7); at s=2 -> (0,4),(1,5),(2,6),(3,7).
- NWL=4, i_READY random 50% -> scoreboard 32 transfers matching the k formula; o_BUSY high throughout; exactly one o_DONE.
